// File: rtl/bringup_sequencer_if.sv
// Handshake bundle between the bring-up sequencer and its init engines,
// plus the on-demand re-run trigger.
interface bringup_sequencer_if #(
    parameter int unsigned NUM_STEPS = 4,
    parameter int unsigned STEP_W    = 2
);
    logic [NUM_STEPS-1:0] step_start;
    logic [NUM_STEPS-1:0] step_done;
    logic                 trig_req;
    logic [STEP_W-1:0]    trig_step;

    modport master (output step_start, input step_done, trig_req, trig_step);
    modport slave  (input step_start, output step_done, trig_req, trig_step);
endinterface

// File: rtl/bringup_sequencer.sv
// Power-up sequencer: startup delay, then NUM_STEPS start/done handshakes with
// per-step dwell and common timeout; on-demand re-run. Retries: STEP_RETRY_EN.
module bringup_sequencer #(
    parameter int unsigned             NUM_STEPS     = 4,
    parameter int unsigned             STEP_W        = 2,
    parameter logic [31:0]             STARTUP_DELAY = 32'd1000000,
    parameter logic [NUM_STEPS*32-1:0] MIN_DELAY     = {NUM_STEPS{32'd1}},
    parameter logic [31:0]             TIMEOUT       = 32'd100000,
    parameter int unsigned             MAX_RETRIES   = 2
) (
    input  logic                       clk_1us,
    input  logic                       RESET,
    bringup_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       error,
    output logic [STEP_W-1:0]          err_step,
    output logic [STEP_W-1:0]          cur_step,
    output logic [3:0]                 state_out
);
`ifdef STEP_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int unsigned SLOTS = 2**STEP_W;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_STARTUP    = 4'd1,
        S_START      = 4'd2,
        S_WAIT       = 4'd3,
        S_TRIG_START = 4'd4,
        S_TRIG_WAIT  = 4'd5,
        S_ERROR      = 4'd6
    } state_t;

    state_t               state;
    logic [31:0]          tick;
    logic [31:0]          retry_cnt;
    logic [NUM_STEPS-1:0] done_s1, done_s2, done_s3, done_flag, done_rise;
    logic                 trig_s1, trig_s2, trig_s3, trig_rise;
    logic [SLOTS-1:0]     flag_ext, rise_ext;
    logic [31:0]          min_tab [SLOTS];
    logic                 step_hit, last_step, trig_ok, retry_ok, timed_out;

    function automatic logic [NUM_STEPS-1:0] onehot(input logic [STEP_W-1:0] idx);
        logic [SLOTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v[NUM_STEPS-1:0];
    endfunction

    // Tables padded to 2**STEP_W so cur_step indexes them at exact width.
    for (genvar g = 0; g < SLOTS; g++) begin : g_min
        if (g < NUM_STEPS) begin : g_used
            assign min_tab[g] = MIN_DELAY[32*g+31:32*g];
        end else begin : g_pad
            assign min_tab[g] = '0;
        end
    end

    assign done_rise = done_s2 & ~done_s3;
    assign trig_rise = trig_s2 & ~trig_s3;
    assign flag_ext  = SLOTS'(done_flag);
    assign rise_ext  = SLOTS'(done_rise);
    assign step_hit  = (flag_ext[cur_step] | rise_ext[cur_step]) && (tick >= min_tab[cur_step]);
    assign last_step = (cur_step == STEP_W'(NUM_STEPS - 1));
    assign trig_ok   = trig_rise && (32'(bus.trig_step) < NUM_STEPS);
    assign timed_out = (tick == TIMEOUT);
    assign retry_ok  = RETRY_EN && (retry_cnt < MAX_RETRIES);

    assign state_out = state;
    assign busy      = (state != S_IDLE) && (state != S_ERROR);
    assign error     = (state == S_ERROR);

    always_ff @(posedge clk_1us) begin
        if (!RESET) begin
            state          <= S_STARTUP;
            tick           <= '0;
            retry_cnt      <= '0;
            bus.step_start <= '0;
            seq_done       <= 1'b0;
            err_step       <= '0;
            cur_step       <= '0;
            done_s1        <= '0;
            done_s2        <= '0;
            done_s3        <= '0;
            done_flag      <= '0;
            trig_s1        <= 1'b0;
            trig_s2        <= 1'b0;
            trig_s3        <= 1'b0;
        end else begin
            done_s1        <= bus.step_done;
            done_s2        <= done_s1;
            done_s3        <= done_s2;
            trig_s1        <= bus.trig_req;
            trig_s2        <= trig_s1;
            trig_s3        <= trig_s2;
            bus.step_start <= '0;
            tick           <= (tick == '1) ? tick : tick + 32'd1;
            done_flag      <= done_flag | done_rise;

            // step_start is loaded on the edge entering a start state so the
            // pulse coincides with that state.
            case (state)
                S_STARTUP: if (tick == STARTUP_DELAY) begin
                    cur_step       <= '0;
                    retry_cnt      <= '0;
                    bus.step_start <= onehot('0);
                    tick           <= '0;
                    state          <= S_START;
                end
                S_START, S_TRIG_START: begin
                    // A level already high before the pulse must not count.
                    done_flag <= (done_flag | done_rise) & ~onehot(cur_step);
                    tick      <= '0;
                    state     <= (state == S_START) ? S_WAIT : S_TRIG_WAIT;
                end
                S_WAIT, S_TRIG_WAIT: begin
                    if (step_hit) begin
                        tick <= '0;
                        if (state == S_TRIG_WAIT) begin
                            state <= S_IDLE;
                        end else if (last_step) begin
                            seq_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            cur_step       <= cur_step + STEP_W'(1);
                            retry_cnt      <= '0;
                            bus.step_start <= onehot(cur_step + STEP_W'(1));
                            state          <= S_START;
                        end
                    end else if (timed_out) begin
                        tick <= '0;
                        if (retry_ok) begin
                            retry_cnt      <= retry_cnt + 32'd1;
                            bus.step_start <= onehot(cur_step);
                            state          <= (state == S_WAIT) ? S_START : S_TRIG_START;
                        end else begin
                            err_step <= cur_step;
                            state    <= S_ERROR;
                        end
                    end
                end
                S_IDLE: if (trig_ok) begin
                    cur_step       <= bus.trig_step;
                    retry_cnt      <= '0;
                    bus.step_start <= onehot(bus.trig_step);
                    tick           <= '0;
                    state          <= S_TRIG_START;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bringup_sequencer.sv
// Directed bench for bringup_sequencer: full sequence, held done, dwell,
// re-run trigger, mid-step reset and timeout (retry count via STEP_RETRY_EN).
`timescale 1ns/1ps
module tb_bringup_sequencer;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = 3;
`ifdef STEP_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    logic          clk_1us = 1'b0;
    logic          RESET   = 1'b0;
    logic          busy, seq_done, error;
    logic [SW-1:0] err_step, cur_step;
    logic [3:0]    state_out;

    int cyc = 0, checks = 0, errors = 0, pulse_cyc = 0;
    int e0, d, p2, n, first, extra, k;

    bringup_sequencer_if #(.NUM_STEPS(NS), .STEP_W(SW)) bus ();

    bringup_sequencer #(
        .NUM_STEPS    (NS),
        .STEP_W       (SW),
        .STARTUP_DELAY(32'd250),
        .MIN_DELAY    ({32'd1, 32'd600, 32'd1, 32'd1}),
        .TIMEOUT      (32'd1000),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_1us  (clk_1us),
        .RESET    (RESET),
        .bus      (bus),
        .busy     (busy),
        .seq_done (seq_done),
        .error    (error),
        .err_step (err_step),
        .cur_step (cur_step),
        .state_out(state_out)
    );

    always #500 clk_1us = ~clk_1us;
    always @(posedge clk_1us) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_n(input int cnt);
        repeat (cnt) @(negedge clk_1us);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_start"}, 32'(bus.step_start), 0);
        check({tag, "_sdone"}, 32'(seq_done), 0);
        check({tag, "_err"},   32'(error), 0);
        check({tag, "_estep"}, 32'(err_step), 0);
        check({tag, "_cur"},   32'(cur_step), 0);
        check({tag, "_busy"},  32'(busy), 1);
        check({tag, "_state"}, 32'(state_out), 1);
    endtask

    // Waits (bounded) for the next pulse, checks value, cycle and 1-cycle width.
    task automatic expect_pulse(input string tag, input logic [NS-1:0] exp,
                                input int exp_cyc, input int budget);
        int w;
        w = 0;
        @(negedge clk_1us);
        while (bus.step_start == '0 && w < budget) begin
            @(negedge clk_1us);
            w++;
        end
        check({tag, "_val"}, 32'(bus.step_start), 32'(exp));
        check({tag, "_cyc"}, cyc, exp_cyc);
        pulse_cyc = cyc;
        @(negedge clk_1us);
        check({tag, "_width"}, 32'(bus.step_start), 0);
    endtask

    task automatic count_pulses(input int cnt, output int hits);
        hits = 0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk_1us);
            if (bus.step_start != '0) hits++;
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.step_done    = '0;
        bus.step_done[1] = 1'b1;
        bus.trig_req     = 1'b0;
        bus.trig_step    = '0;

        // Reset and ordered sequence; step 1 done held high from reset.
        step_n(4);
        check_reset("rst");
        e0 = cyc;
        RESET = 1'b1;
        expect_pulse("p0", 4'b0001, e0 + 251, 300);
        check("wait0_state", 32'(state_out), 3);
        step_n(9);
        bus.step_done[0] = 1'b1;
        d = cyc;
        expect_pulse("p1", 4'b0010, d + 3, 10);

        count_pulses(20, n);
        check("held_done_nopulse", n, 0);
        check("held_done_state", 32'(state_out), 3);
        bus.step_done = '0;
        step_n(3);
        bus.step_done[1] = 1'b1;
        d = cyc;
        expect_pulse("p2", 4'b0100, d + 3, 10);

        // Step 2 dwell of 600 ticks dominates its early done.
        p2 = pulse_cyc;
        step_n(9);
        bus.step_done[2] = 1'b1;
        expect_pulse("p3_dwell", 4'b1000, p2 + 602, 700);
        step_n(9);
        bus.step_done[3] = 1'b1;
        d = cyc;
        step_n(2);
        check("seq_pre_done", 32'(seq_done), 0);
        step_n(1);
        check("seq_done", 32'(seq_done), 1);
        check("seq_idle", 32'(state_out), 0);
        check("seq_busy", 32'(busy), 0);
        check("seq_cur", 32'(cur_step), 3);

        // Re-run step 1 with trig_req held for 50 ticks.
        bus.step_done = '0;
        step_n(5);
        bus.trig_step = 3'd1;
        bus.trig_req  = 1'b1;
        d = cyc;
        n = 0;
        first = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_1us);
            if (bus.step_start != '0) begin
                n++;
                if (first < 0) first = cyc;
                check("trig_val", 32'(bus.step_start), 32'h2);
            end
        end
        check("trig_count", n, 1);
        check("trig_cyc", first, d + 3);
        check("trig_state", 32'(state_out), 5);
        check("trig_seqdone", 32'(seq_done), 1);
        bus.trig_req = 1'b0;
        step_n(2);
        bus.step_done[1] = 1'b1;
        step_n(3);
        check("trig_back_idle", 32'(state_out), 0);
        check("trig_cur", 32'(cur_step), 1);
        check("trig_seqdone2", 32'(seq_done), 1);

        bus.step_done = '0;
        bus.trig_step = 3'd7;
        bus.trig_req  = 1'b1;
        step_n(5);
        bus.trig_req = 1'b0;
        count_pulses(20, n);
        check("trig_oor_nopulse", n, 0);
        check("trig_oor_state", 32'(state_out), 0);

        // Reset in the middle of step 1's wait.
        RESET = 1'b0;
        step_n(2);
        e0 = cyc;
        RESET = 1'b1;
        expect_pulse("r_p0", 4'b0001, e0 + 251, 300);
        step_n(9);
        bus.step_done[0] = 1'b1;
        d = cyc;
        expect_pulse("r_p1", 4'b0010, d + 3, 10);
        step_n(4);
        check("mid_state", 32'(state_out), 3);
        check("mid_cur", 32'(cur_step), 1);
        RESET = 1'b0;
        bus.step_done = '0;
        step_n(1);
        check_reset("rst_mid");
        count_pulses(3, n);
        check("rst_hold_nopulse", n, 0);
        e0 = cyc;
        RESET = 1'b1;
        expect_pulse("re_p0", 4'b0001, e0 + 251, 300);

        // Step 2 never completes: timeout (with optional retries) to S_ERROR.
        step_n(9);
        bus.step_done[0] = 1'b1;
        d = cyc;
        expect_pulse("re_p1", 4'b0010, d + 3, 10);
        step_n(9);
        bus.step_done[1] = 1'b1;
        d = cyc;
        expect_pulse("re_p2", 4'b0100, d + 3, 10);
        p2 = pulse_cyc;
        extra = 0;
        k = 0;
        while (error == 1'b0 && k < 3500) begin
            @(negedge clk_1us);
            if (bus.step_start != '0) begin
                extra++;
                check("retry_val", 32'(bus.step_start), 32'h4);
            end
            k++;
        end
        check("to_pulses", extra + 1, RETRIES + 1);
        check("to_cyc", cyc, p2 + (RETRIES + 1) * 1002);
        check("to_error", 32'(error), 1);
        check("to_estep", 32'(err_step), 2);
        check("to_state", 32'(state_out), 6);
        check("to_busy", 32'(busy), 0);
        check("to_seqdone", 32'(seq_done), 0);
        bus.step_done[2] = 1'b1;
        count_pulses(50, n);
        check("err_nopulse", n, 0);
        check("err_sticky", 32'(state_out), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
